// File: rtl/delay_pkg.sv
// Shared width helpers and delay clamping for the programmable delay line.
package delay_pkg;

  function automatic int dly_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Keep at least one pointer bit so a degenerate depth still elaborates.
  function automatic int ptr_w(input int max_len);
    return (max_len > 2) ? $clog2(max_len) : 1;
  endfunction

  // A zero request is treated as the shortest delay; anything too long saturates.
  function automatic int clamp_dly(input int d, input int max_len);
    if (d < 1)
      return 1;
    else if (d > max_len)
      return max_len;
    else
      return d;
  endfunction

endpackage

// File: rtl/delay_prog.sv
// Programmable sample delay: a circular register buffer read at wr_ptr - dly_cur,
// with latency measured in ena advances rather than clocks.
module delay_prog
  import delay_pkg::*;
#(
  parameter int MAX_LENGTH     = 16,
  parameter int WIDTH          = 8,
  parameter int CHANNELS       = 1,
  parameter int DEFAULT_LENGTH = 2
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                ena,
  input  logic [CHANNELS*WIDTH-1:0]           in,
  input  logic [dly_w(MAX_LENGTH)-1:0]        dly,
  input  logic                                dly_load,
  output logic [CHANNELS*WIDTH-1:0]           out,
  output logic                                out_valid,
  output logic [dly_w(MAX_LENGTH)-1:0]        dly_cur
);

  localparam int DLY_W = dly_w(MAX_LENGTH);
  localparam int PTR_W = ptr_w(MAX_LENGTH);
  localparam int DW    = CHANNELS * WIDTH;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_LENGTH - 1);
  localparam logic [DLY_W-1:0] FILL_MAX = DLY_W'(MAX_LENGTH);
  localparam logic [DLY_W-1:0] DLY_RST  = DLY_W'(DEFAULT_LENGTH);
  localparam logic [DLY_W:0]   LEN_EXT  = (DLY_W + 1)'(MAX_LENGTH);

  logic [DW-1:0]    mem [MAX_LENGTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [DLY_W-1:0] fill;
  logic [PTR_W-1:0] rd_ptr;
  logic [DLY_W:0]   rd_sum;
  logic [DLY_W:0]   rd_wrapped;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < MAX_LENGTH; i++)
        mem[i] <= '0;
      wr_ptr  <= '0;
      fill    <= '0;
      dly_cur <= DLY_RST;
    end else begin
      if (ena) begin
        mem[wr_ptr] <= in;
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        if (fill != FILL_MAX)
          fill <= fill + 1'b1;
      end
      if (dly_load)
        dly_cur <= DLY_W'(clamp_dly(int'(dly), MAX_LENGTH));
    end
  end

  // Explicit modulo: add the depth before subtracting so non-power-of-two depths wrap correctly.
  always_comb begin
    rd_sum     = (DLY_W + 1)'(wr_ptr) + LEN_EXT - (DLY_W + 1)'(dly_cur);
    rd_wrapped = (rd_sum >= LEN_EXT) ? rd_sum - LEN_EXT : rd_sum;
    rd_ptr     = rd_wrapped[PTR_W-1:0];
  end

  assign out       = mem[rd_ptr];
  assign out_valid = (fill >= dly_cur);

endmodule

// File: tb/tb_delay_prog.sv
// Directed bench for delay_prog with a history-based scoreboard of expected outputs.
module tb_delay_prog;

  localparam int ML = 8;
  localparam int W  = 8;
  localparam int CH = 2;
  localparam int DL = 2;
  localparam int DW = CH * W;

  typedef struct packed {
    logic [DW-1:0] out;
    logic          valid;
    logic [3:0]    dly;
  } exp_t;

  logic          clk = 1'b0;
  logic          nrst;
  logic          ena;
  logic [DW-1:0] in;
  logic [3:0]    dly;
  logic          dly_load;
  logic [DW-1:0] out;
  logic          out_valid;
  logic [3:0]    dly_cur;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] hist[$];
  int            m_dly;
  exp_t          sb[$];

  delay_prog #(
    .MAX_LENGTH(ML), .WIDTH(W), .CHANNELS(CH), .DEFAULT_LENGTH(DL)
  ) dut (
    .clk(clk), .nrst(nrst), .ena(ena), .in(in), .dly(dly), .dly_load(dly_load),
    .out(out), .out_valid(out_valid), .dly_cur(dly_cur)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic exp_t predict();
    exp_t e;
    int nw;
    nw      = hist.size();
    e.dly   = 4'(m_dly);
    e.valid = (nw >= m_dly);
    e.out   = e.valid ? hist[nw - m_dly] : '0;
    return e;
  endfunction

  task automatic step(input string tag, input logic rn, input logic en, input logic [DW-1:0] din,
                      input logic ld, input logic [3:0] d);
    exp_t e;
    @(negedge clk);
    nrst = rn; ena = en; in = din; dly_load = ld; dly = d;
    if (!rn) begin
      hist.delete();
      m_dly = DL;
    end else begin
      if (en) hist.push_back(din);
      if (ld) m_dly = (d == 0) ? 1 : (int'(d) > ML ? ML : int'(d));
    end
    sb.push_back(predict());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".out"},     out,               e.out);
    check({tag, ".valid"},   DW'(out_valid),    DW'(e.valid));
    check({tag, ".dly_cur"}, DW'(dly_cur),      DW'(e.dly));
  endtask

  task automatic wr(input string tag, input logic [DW-1:0] din);
    step(tag, 1'b1, 1'b1, din, 1'b0, 4'd0);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b1, 1'b0, '0, 1'b0, 4'd0);
  endtask

  task automatic rst(input string tag);
    step(tag, 1'b0, 1'b0, '0, 1'b0, 4'd0);
  endtask

  task automatic load(input string tag, input logic [3:0] d);
    step(tag, 1'b1, 1'b0, '0, 1'b1, d);
  endtask

  initial begin
    int n;
    nrst = 1'b0; ena = 1'b0; in = '0; dly = '0; dly_load = 1'b0;
    m_dly = DL;

    // Reset state
    rst("reset0");
    rst("reset1");
    check("post_reset.out", out, '0);
    check("post_reset.dly_cur", DW'(dly_cur), DW'(DL));

    // Continuous stream: out after edge k is {k-1, k+0x7F}
    for (n = 1; n <= 10; n++) begin
      wr("stream", {8'(n), 8'(n + 8'h80)});
      if (n >= 2) check("stream.abs", out, {8'(n - 1), 8'(n + 8'h7F)});
      else        check("stream.first_invalid", DW'(out_valid), '0);
    end

    // Gapped ena: output moves only on write edges
    for (int i = 0; i < 4; i++) begin
      wr("gap_wr", {8'(n), 8'(n + 8'h80)});
      n++;
      idle("gap_idle");
    end

    // Clamp and full-depth reads
    rst("r2");
    for (int v = 1; v <= 8; v++) wr("fill8", {8'(v), 8'(v)});
    load("ld8", 4'd8);
    check("ld8.oldest", out, 16'h0101);
    load("ld0", 4'd0);
    check("ld0.newest", out, 16'h0808);
    load("ld15", 4'd15);
    check("ld15.sat", DW'(dly_cur), DW'(8));
    wr("wrap_wr", 16'h0909);
    load("ld3", 4'd3);

    // Delay increased past fill, then refilled
    rst("r3");
    for (int v = 1; v <= 3; v++) wr("fill3", {8'(v + 16), 8'(v + 32)});
    load("ld5", 4'd5);
    check("ld5.invalid", DW'(out_valid), '0);
    wr("fill4", 16'h1424);
    wr("fill5", 16'h1525);
    check("ld5.first", out, 16'h1121);
    load("ld1_dec", 4'd1);

    // Simultaneous load and write at wr_ptr=7
    rst("r4");
    for (int v = 0; v < 7; v++) wr("pre7", {8'(v + 64), 8'(v + 96)});
    step("ld_wr7", 1'b1, 1'b1, 16'hABCD, 1'b1, 4'd3);
    check("ld_wr7.out", out, 16'h4565);
    wr("after_wrap", 16'h1234);
    check("after_wrap.out", out, 16'h4666);

    // Reset wins over ena and load
    step("rst_pri", 1'b0, 1'b1, 16'hFFFF, 1'b1, 4'd5);
    check("rst_pri.dly_cur", DW'(dly_cur), DW'(DL));
    wr("post_rst1", 16'h0102);
    wr("post_rst2", 16'h0304);
    check("post_rst2.out", out, 16'h0102);

    if (sb.size() != 0) begin
      total++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
